// File: rtl/trap_pipe_ctrl_if.sv
// Pipeline-facing bundle of trap_pipe_ctrl: redirect sources, trap requests,
// interrupt lines and CSR values in; redirect, ack, CSR strobes and stage controls out.
interface trap_pipe_ctrl_if #(
  parameter int unsigned NUM_IRQ = 8
);
  localparam int unsigned IDW = $clog2(NUM_IRQ);

  logic               branch_taken;
  logic [31:0]        branch_target;
  logic               jump_taken;
  logic [31:0]        jump_target;
  logic [31:0]        pc_if;
  logic               exc_valid;
  logic [4:0]         exc_code;
  logic               exc_mret;
  logic               exc_wfi;
  logic               exc_fence;
  logic [NUM_IRQ-1:0] irq_pending;
  logic               mstatus_mie;
  logic [31:0]        mtvec;
  logic [31:0]        mepc;

  logic               set_pc_valid;
  logic [31:0]        set_pc;
  logic               fetch_enable;
  logic               irq_ack;
  logic [IDW-1:0]     irq_ack_id;
  logic               mcause_update;
  logic [31:0]        mcause;
  logic               mepc_update;
  logic               mepc_sel;
  logic [4:0]         flush;
  logic [4:0]         stall;
  logic               sleeping;

  // Pipeline / CSR side
  modport master (
    output branch_taken, branch_target, jump_taken, jump_target, pc_if,
           exc_valid, exc_code, exc_mret, exc_wfi, exc_fence,
           irq_pending, mstatus_mie, mtvec, mepc,
    input  set_pc_valid, set_pc, fetch_enable, irq_ack, irq_ack_id,
           mcause_update, mcause, mepc_update, mepc_sel, flush, stall, sleeping
  );

  // Trap controller side
  modport slave (
    input  branch_taken, branch_target, jump_taken, jump_target, pc_if,
           exc_valid, exc_code, exc_mret, exc_wfi, exc_fence,
           irq_pending, mstatus_mie, mtvec, mepc,
    output set_pc_valid, set_pc, fetch_enable, irq_ack, irq_ack_id,
           mcause_update, mcause, mepc_update, mepc_sel, flush, stall, sleeping
  );
endinterface

// File: rtl/trap_pipe_ctrl.sv
// Trap and pipeline controller: exceptions, prioritised interrupts, fetch redirect,
// flush/stall sequencing and WFI sleep. Optional sleep timeout: TRAP_PIPE_CTRL_WFI_TIMEOUT_EN.
module trap_pipe_ctrl #(
  parameter int unsigned NUM_IRQ      = 8,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned WFI_TIMEOUT  = 1024
) (
  input logic              clk,
  input logic              reset_n,
  trap_pipe_ctrl_if.slave  bus
);
  localparam int unsigned IDW = $clog2(NUM_IRQ);
  localparam int unsigned FCW = 3;

  if (NUM_IRQ < 3 || NUM_IRQ > 32 || FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 ||
      WFI_TIMEOUT < 1) begin : g_param_check
    $error("trap_pipe_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_SLEEP, S_WAKEUP} state_t;
  typedef enum logic [2:0] {K_EXC, K_MRET, K_WFI, K_FENCE, K_IRQ} kind_t;

  state_t           state_q;
  kind_t            kind_q;
  logic [FCW-1:0]   flush_cnt_q;
`ifdef TRAP_PIPE_CTRL_WFI_TIMEOUT_EN
  logic [31:0]      sleep_cnt_q;
`endif

  logic             set_pc_valid_q;
  logic [31:0]      set_pc_q;
  logic             fetch_enable_q;
  logic             irq_ack_q;
  logic [IDW-1:0]   irq_ack_id_q;
  logic             mcause_update_q;
  logic [31:0]      mcause_q;
  logic             mepc_update_q;
  logic             mepc_sel_q;
  logic [4:0]       flush_q;
  logic [4:0]       stall_q;
  logic             sleeping_q;

  logic [NUM_IRQ-1:0] eligible;
  logic               sel_any;
  logic               pend_any;
  logic [IDW-1:0]     sel_id;
  logic [4:0]         sel_cause;
  logic [31:0]        trap_base;
  logic [31:0]        irq_pc;
  logic               flush_done;
  logic               wake_c;

  // Interrupt arbitration: highest platform line, then MEI, MSI, MTI
  always_comb begin
    eligible = bus.irq_pending & {NUM_IRQ{bus.mstatus_mie}};
    sel_any  = |eligible;
    pend_any = |bus.irq_pending;
    sel_id   = '0;
    if (eligible[1]) sel_id = IDW'(1);
    if (eligible[0]) sel_id = IDW'(0);
    if (eligible[2]) sel_id = IDW'(2);
    for (int unsigned i = 3; i < NUM_IRQ; i++) begin
      if (eligible[i]) sel_id = IDW'(i);
    end
    if (sel_id == IDW'(0))      sel_cause = 5'd3;
    else if (sel_id == IDW'(1)) sel_cause = 5'd7;
    else if (sel_id == IDW'(2)) sel_cause = 5'd11;
    else                        sel_cause = 5'(32'(sel_id) + 32'd13);
    trap_base = {bus.mtvec[31:2], 2'b00};
    irq_pc    = (bus.mtvec[1:0] == 2'b01) ? trap_base + {25'd0, sel_cause, 2'b00}
                                          : trap_base;
  end

  // Wake from WFI: pending line, or optional sleep timeout
  always_comb begin
    flush_done = (flush_cnt_q == FCW'(FLUSH_CYCLES - 1));
    wake_c     = 1'b0;
    if (state_q == S_FLUSH && flush_done && kind_q == K_WFI && pend_any) wake_c = 1'b1;
    if (state_q == S_SLEEP && pend_any) wake_c = 1'b1;
`ifdef TRAP_PIPE_CTRL_WFI_TIMEOUT_EN
    if (state_q == S_SLEEP && !pend_any && sleep_cnt_q == 32'(WFI_TIMEOUT - 1)) wake_c = 1'b1;
`endif
  end

  // State machine with registered outputs; first-cycle actions computed on entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      kind_q          <= K_EXC;
      flush_cnt_q     <= '0;
`ifdef TRAP_PIPE_CTRL_WFI_TIMEOUT_EN
      sleep_cnt_q     <= '0;
`endif
      set_pc_valid_q  <= 1'b0;
      set_pc_q        <= '0;
      fetch_enable_q  <= 1'b1;
      irq_ack_q       <= 1'b0;
      irq_ack_id_q    <= '0;
      mcause_update_q <= 1'b0;
      mcause_q        <= '0;
      mepc_update_q   <= 1'b0;
      mepc_sel_q      <= 1'b0;
      flush_q         <= '0;
      stall_q         <= '0;
      sleeping_q      <= 1'b0;
    end else begin
      set_pc_valid_q  <= 1'b0;
      irq_ack_q       <= 1'b0;
      mcause_update_q <= 1'b0;
      mepc_update_q   <= 1'b0;
      flush_q         <= '0;
      stall_q         <= '0;
      fetch_enable_q  <= 1'b1;
      sleeping_q      <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (bus.exc_valid || sel_any) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= '0;
            flush_q     <= '1;
            if (bus.exc_valid) begin
              if (bus.exc_mret) begin
                kind_q         <= K_MRET;
                set_pc_valid_q <= 1'b1;
                set_pc_q       <= bus.mepc;
              end else if (bus.exc_fence) begin
                kind_q         <= K_FENCE;
                set_pc_valid_q <= 1'b1;
                set_pc_q       <= bus.pc_if;
              end else if (bus.exc_wfi) begin
                kind_q        <= K_WFI;
                mepc_update_q <= 1'b1;
                mepc_sel_q    <= 1'b1;
              end else begin
                kind_q          <= K_EXC;
                set_pc_valid_q  <= 1'b1;
                set_pc_q        <= trap_base;
                mcause_update_q <= 1'b1;
                mcause_q        <= {1'b0, 26'd0, bus.exc_code};
                mepc_update_q   <= 1'b1;
                mepc_sel_q      <= 1'b0;
              end
            end else begin
              kind_q          <= K_IRQ;
              set_pc_valid_q  <= 1'b1;
              set_pc_q        <= irq_pc;
              mcause_update_q <= 1'b1;
              mcause_q        <= {1'b1, 26'd0, sel_cause};
              irq_ack_q       <= 1'b1;
              irq_ack_id_q    <= sel_id;
              mepc_update_q   <= 1'b1;
              mepc_sel_q      <= 1'b0;
            end
          end else begin
            set_pc_valid_q <= bus.branch_taken | bus.jump_taken;
            if (bus.branch_taken)    set_pc_q <= bus.branch_target;
            else if (bus.jump_taken) set_pc_q <= bus.jump_target;
            flush_q <= (bus.branch_taken | bus.jump_taken) ? 5'b00011 : 5'b00000;
          end
        end
        S_FLUSH: begin
          if (!flush_done) begin
            flush_cnt_q <= FCW'(flush_cnt_q + FCW'(1));
            flush_q     <= '1;
          end else if (kind_q != K_WFI) begin
            state_q <= S_IDLE;
          end else if (!pend_any) begin
            state_q        <= S_SLEEP;
            fetch_enable_q <= 1'b0;
            stall_q        <= '1;
            sleeping_q     <= 1'b1;
`ifdef TRAP_PIPE_CTRL_WFI_TIMEOUT_EN
            sleep_cnt_q    <= '0;
`endif
          end
        end
        S_SLEEP: begin
          if (!wake_c) begin
            fetch_enable_q <= 1'b0;
            stall_q        <= '1;
            sleeping_q     <= 1'b1;
`ifdef TRAP_PIPE_CTRL_WFI_TIMEOUT_EN
            sleep_cnt_q    <= sleep_cnt_q + 32'd1;
`endif
          end
        end
        S_WAKEUP: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase

      // mepc already captured with mepc_sel=1 at WFI entry, so no mepc write here
      if (wake_c) begin
        state_q        <= S_WAKEUP;
        set_pc_valid_q <= 1'b1;
        if (bus.mstatus_mie && sel_any) begin
          set_pc_q        <= irq_pc;
          mcause_update_q <= 1'b1;
          mcause_q        <= {1'b1, 26'd0, sel_cause};
          irq_ack_q       <= 1'b1;
          irq_ack_id_q    <= sel_id;
        end else begin
          set_pc_q <= bus.mepc;
        end
      end
    end
  end

  assign bus.set_pc_valid  = set_pc_valid_q;
  assign bus.set_pc        = set_pc_q;
  assign bus.fetch_enable  = fetch_enable_q;
  assign bus.irq_ack       = irq_ack_q;
  assign bus.irq_ack_id    = irq_ack_id_q;
  assign bus.mcause_update = mcause_update_q;
  assign bus.mcause        = mcause_q;
  assign bus.mepc_update   = mepc_update_q;
  assign bus.mepc_sel      = mepc_sel_q;
  assign bus.flush         = flush_q;
  assign bus.stall         = stall_q;
  assign bus.sleeping      = sleeping_q;

endmodule

// File: tb/tb_trap_pipe_ctrl.sv
// Directed bench for trap_pipe_ctrl (NUM_IRQ=8, FLUSH_CYCLES=2): traps, irq priority,
// redirects, WFI sleep/wake and reset from SLEEP.
module tb_trap_pipe_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  trap_pipe_ctrl_if #(.NUM_IRQ(8)) bus ();

  trap_pipe_ctrl #(.NUM_IRQ(8), .FLUSH_CYCLES(2), .WFI_TIMEOUT(1024)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_trap();
    bus.exc_valid    = 1'b0;
    bus.exc_code     = 5'd0;
    bus.exc_mret     = 1'b0;
    bus.exc_wfi      = 1'b0;
    bus.exc_fence    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump_taken   = 1'b0;
  endtask

  // Enter WFI from IDLE and ride the two flush cycles into SLEEP
  task automatic enter_sleep();
    bus.exc_valid = 1'b1;
    bus.exc_wfi   = 1'b1;
    step();
    clr_trap();
    step();
    step();
  endtask

  initial begin
    clr_trap();
    bus.branch_target = 32'h0;
    bus.jump_target   = 32'h0;
    bus.pc_if         = 32'h0;
    bus.irq_pending   = 8'h00;
    bus.mstatus_mie   = 1'b0;
    bus.mtvec         = 32'h0;
    bus.mepc          = 32'h0;
    step();
    step();
    check("rst_fetch_enable", 32'(bus.fetch_enable), 32'h1);
    check("rst_stall", 32'(bus.stall), 32'h0);
    check("rst_flush", 32'(bus.flush), 32'h0);
    check("rst_set_pc_valid", 32'(bus.set_pc_valid), 32'h0);
    check("rst_sleeping", 32'(bus.sleeping), 32'h0);
    reset_n = 1'b1;
    step();

    // Synchronous exception, vectored mtvec still uses base
    bus.exc_valid = 1'b1; bus.exc_code = 5'd2; bus.mtvec = 32'h0000_0101;
    step();
    clr_trap();
    check("exc_valid", 32'(bus.set_pc_valid), 32'h1);
    check("exc_pc", bus.set_pc, 32'h0000_0100);
    check("exc_mcause", bus.mcause, 32'h0000_0002);
    check("exc_mcause_upd", 32'(bus.mcause_update), 32'h1);
    check("exc_mepc_upd", 32'(bus.mepc_update), 32'h1);
    check("exc_mepc_sel", 32'(bus.mepc_sel), 32'h0);
    check("exc_flush0", 32'(bus.flush), 32'h1F);
    step();
    check("exc_flush1", 32'(bus.flush), 32'h1F);
    check("exc_strobe_drop", 32'(bus.set_pc_valid), 32'h0);
    check("exc_mcause_upd_drop", 32'(bus.mcause_update), 32'h0);
    step();
    check("exc_flush_end", 32'(bus.flush), 32'h0);

    // MEI, vectored: 0x200 + 4*11
    bus.irq_pending = 8'h04; bus.mstatus_mie = 1'b1; bus.mtvec = 32'h0000_0201;
    step();
    bus.irq_pending = 8'h00;
    check("mei_pc", bus.set_pc, 32'h0000_022C);
    check("mei_mcause", bus.mcause, 32'h8000_000B);
    check("mei_ack", 32'(bus.irq_ack), 32'h1);
    check("mei_ack_id", 32'(bus.irq_ack_id), 32'h2);
    step();
    check("mei_ack_drop", 32'(bus.irq_ack), 32'h0);
    step();

    // Line 7 beats MEI and MSI; MEI next once line 7 clears
    bus.irq_pending = 8'b1000_0101;
    step();
    bus.irq_pending = 8'b0000_0101;
    check("l7_ack_id", 32'(bus.irq_ack_id), 32'h7);
    check("l7_mcause", bus.mcause, 32'h8000_0014);
    check("l7_pc", bus.set_pc, 32'h0000_0250);
    step();
    step();
    step();
    check("l2_after_l7_id", 32'(bus.irq_ack_id), 32'h2);
    check("l2_after_l7_mcause", bus.mcause, 32'h8000_000B);
    bus.irq_pending = 8'h01;
    step();
    step();
    step();
    check("l0_last_id", 32'(bus.irq_ack_id), 32'h0);
    check("l0_last_mcause", bus.mcause, 32'h8000_0003);
    bus.irq_pending = 8'h00;
    step();
    step();

    // Exception + MTI + branch together; MTI taken afterwards
    bus.mtvec = 32'h0000_0100;
    bus.exc_valid = 1'b1; bus.exc_code = 5'd5; bus.irq_pending = 8'h02;
    bus.branch_taken = 1'b1; bus.branch_target = 32'hDEAD_0000;
    step();
    clr_trap();
    check("mix_pc", bus.set_pc, 32'h0000_0100);
    check("mix_mcause", bus.mcause, 32'h0000_0005);
    check("mix_no_ack", 32'(bus.irq_ack), 32'h0);
    step();
    step();
    step();
    check("mix_irq_ack", 32'(bus.irq_ack), 32'h1);
    check("mix_irq_id", 32'(bus.irq_ack_id), 32'h1);
    check("mix_irq_mcause", bus.mcause, 32'h8000_0007);
    check("mix_irq_pc", bus.set_pc, 32'h0000_0100);
    bus.irq_pending = 8'h00;
    step();
    step();

    // Masked interrupt is not taken
    bus.mstatus_mie = 1'b0; bus.irq_pending = 8'h01;
    step();
    check("masked_no_redirect", 32'(bus.set_pc_valid), 32'h0);
    check("masked_no_flush", 32'(bus.flush), 32'h0);
    bus.irq_pending = 8'h00;

    // Branch/jump redirects
    bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_4000;
    bus.jump_taken = 1'b1; bus.jump_target = 32'h0000_5000;
    step();
    check("bj_valid", 32'(bus.set_pc_valid), 32'h1);
    check("bj_pc", bus.set_pc, 32'h0000_4000);
    check("bj_flush", 32'(bus.flush), 32'h03);
    bus.branch_taken = 1'b0;
    step();
    check("j_pc", bus.set_pc, 32'h0000_5000);
    clr_trap();
    step();
    check("bj_idle_valid", 32'(bus.set_pc_valid), 32'h0);
    check("bj_idle_flush", 32'(bus.flush), 32'h0);

    // mret
    bus.exc_valid = 1'b1; bus.exc_mret = 1'b1; bus.mepc = 32'h0000_1234;
    step();
    clr_trap();
    check("mret_pc", bus.set_pc, 32'h0000_1234);
    check("mret_valid", 32'(bus.set_pc_valid), 32'h1);
    check("mret_no_mcause", 32'(bus.mcause_update), 32'h0);
    check("mret_no_mepc", 32'(bus.mepc_update), 32'h0);
    step();
    step();

    // fence refetches pc_if
    bus.exc_valid = 1'b1; bus.exc_fence = 1'b1; bus.pc_if = 32'h0000_0300;
    step();
    clr_trap();
    check("fence_pc", bus.set_pc, 32'h0000_0300);
    check("fence_no_mcause", 32'(bus.mcause_update), 32'h0);
    step();
    step();

    // WFI -> SLEEP -> MTI wake with mie=1
    bus.mstatus_mie = 1'b1; bus.pc_if = 32'h0000_0080;
    bus.exc_valid = 1'b1; bus.exc_wfi = 1'b1;
    step();
    clr_trap();
    check("wfi_no_redirect", 32'(bus.set_pc_valid), 32'h0);
    check("wfi_mepc_upd", 32'(bus.mepc_update), 32'h1);
    check("wfi_mepc_sel", 32'(bus.mepc_sel), 32'h1);
    check("wfi_no_mcause", 32'(bus.mcause_update), 32'h0);
    step();
    step();
    check("sleep_fetch_en", 32'(bus.fetch_enable), 32'h0);
    check("sleep_stall", 32'(bus.stall), 32'h1F);
    check("sleep_flag", 32'(bus.sleeping), 32'h1);
    check("sleep_flush", 32'(bus.flush), 32'h0);
    step();
    check("sleep_hold", 32'(bus.sleeping), 32'h1);
    bus.irq_pending = 8'h02;
    step();
    bus.irq_pending = 8'h00;
    check("wake_mcause", bus.mcause, 32'h8000_0007);
    check("wake_pc", bus.set_pc, 32'h0000_0100);
    check("wake_valid", 32'(bus.set_pc_valid), 32'h1);
    check("wake_ack_id", 32'(bus.irq_ack_id), 32'h1);
    check("wake_no_mepc", 32'(bus.mepc_update), 32'h0);
    check("wake_mepc_sel", 32'(bus.mepc_sel), 32'h1);
    check("wake_fetch_en", 32'(bus.fetch_enable), 32'h1);
    step();
    check("wake_to_idle", 32'(bus.set_pc_valid), 32'h0);

    // WFI wake with mie=0 returns to mepc
    bus.mstatus_mie = 1'b0; bus.mepc = 32'h0000_2000;
    enter_sleep();
    check("sleep2_flag", 32'(bus.sleeping), 32'h1);
    bus.irq_pending = 8'h01;
    step();
    bus.irq_pending = 8'h00;
    check("wake0_pc", bus.set_pc, 32'h0000_2000);
    check("wake0_valid", 32'(bus.set_pc_valid), 32'h1);
    check("wake0_no_ack", 32'(bus.irq_ack), 32'h0);
    check("wake0_no_mcause", 32'(bus.mcause_update), 32'h0);
    step();

    // Reset during SLEEP
    enter_sleep();
    check("sleep3_flag", 32'(bus.sleeping), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstsleep_fetch_en", 32'(bus.fetch_enable), 32'h1);
    check("rstsleep_flag", 32'(bus.sleeping), 32'h0);
    check("rstsleep_stall", 32'(bus.stall), 32'h0);
    #1;
    reset_n = 1'b1;
    step();
    check("post_rst_flag", 32'(bus.sleeping), 32'h0);
    check("post_rst_fetch_en", 32'(bus.fetch_enable), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
